fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined RV32I core.
// Holds the program counter, drives the instruction-memory address and
// captures the returned word into the IF/ID pipeline register for decode.
// Execute-stage redirects squash the wrong-path fetch, and stall/flush
// requests from the hazard unit are applied here. The stage also counts
// instructions delivered to decode.
module fetch_stage #(
   parameter int                      ADDR_WIDTH = 32,
   parameter int                      DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0]   NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_f,
   input  logic                  stall_d,
   input  logic                  flush_d,
   input  logic                  pc_src_e,
   input  logic [ADDR_WIDTH-1:0] pc_target_e,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_d,
   output logic [ADDR_WIDTH-1:0] pc_d,
   output logic [ADDR_WIDTH-1:0] pc_plus4_d,
   output logic                  valid_d,
   output logic                  misaligned_d,
   output logic [31:0]           fetch_count
);

   logic [ADDR_WIDTH-1:0] pc_f;
   logic [ADDR_WIDTH-1:0] pc_plus4_f;
   logic                  misaligned_f;
   logic                  bubble_d;
   logic                  load_d;

   // Memory is addressed straight from the PC register. The +4 wraps
   // naturally at the top of the address space.
   assign instr_addr   = pc_f;
   assign pc_plus4_f   = pc_f + ADDR_WIDTH'(4);
   assign misaligned_f = (pc_f[1:0] != 2'b00);

   // A resolved redirect squashes the instruction fetched this cycle,
   // because that instruction came from the wrong path.
   assign bubble_d = flush_d | pc_src_e;
   assign load_d   = ~bubble_d & ~stall_d;

   // PC update: a redirect beats a stall, and a stall beats sequential fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f <= RESET_PC;
      end else if (pc_src_e) begin
         pc_f <= pc_target_e;
      end else if (!stall_f) begin
         pc_f <= pc_plus4_f;
      end
   end

   // IF/ID register: a bubble beats a hold, and a hold beats a load.
   always_ff @(posedge clk) begin
      if (reset || bubble_d) begin
         instr_d      <= NOP_INSTR;
         pc_d         <= '0;
         pc_plus4_d   <= '0;
         valid_d      <= 1'b0;
         misaligned_d <= 1'b0;
      end else if (load_d) begin
         instr_d      <= instr;
         pc_d         <= pc_f;
         pc_plus4_d   <= pc_plus4_f;
         valid_d      <= 1'b1;
         misaligned_d <= misaligned_f;
      end
   end

   // Count only the cycles where a real instruction enters IF/ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (load_d) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// A behavioural model of the stage pushes the expected post-edge outputs
// into a queue as each step is driven. After the clock edge the entry is
// popped and compared with the DUT outputs. Directed constant checks are
// added at the points of interest.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        pc_src_e;
   logic [31:0] pc_target_e;
   logic [31:0] instr_addr;
   logic [31:0] instr;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic        misaligned_d;
   logic [31:0] fetch_count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      logic        mis;
      logic [31:0] count;
   } exp_t;

   exp_t expQ[$];

   int errors = 0;
   int checks = 0;

   // Model state.
   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mPcD;
   logic [31:0] mPc4D;
   logic        mValid;
   logic        mMis;
   logic [31:0] mCount;

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .flush_d      (flush_d),
      .pc_src_e     (pc_src_e),
      .pc_target_e  (pc_target_e),
      .instr_addr   (instr_addr),
      .instr        (instr),
      .instr_d      (instr_d),
      .pc_d         (pc_d),
      .pc_plus4_d   (pc_plus4_d),
      .valid_d      (valid_d),
      .misaligned_d (misaligned_d),
      .fetch_count  (fetch_count)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory is word-indexed, so a misaligned PC returns the
   // word of its enclosing aligned address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
   endfunction

   assign instr = memWord(instr_addr);

   // Compares one observed value against its expected value.
   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Pops the oldest expected entry and compares every output against it.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
      end else begin
         e = expQ.pop_front();
         checkValue({tag, ".instr_addr"},   instr_addr,            e.addr);
         checkValue({tag, ".instr_d"},      instr_d,               e.instr);
         checkValue({tag, ".pc_d"},         pc_d,                  e.pc);
         checkValue({tag, ".pc_plus4_d"},   pc_plus4_d,            e.pc4);
         checkValue({tag, ".valid_d"},      {31'd0, valid_d},      {31'd0, e.valid});
         checkValue({tag, ".misaligned_d"}, {31'd0, misaligned_d}, {31'd0, e.mis});
         checkValue({tag, ".fetch_count"},  fetch_count,           e.count);
      end
   endtask

   // Drives one cycle of inputs, advances the model, pushes the expected
   // outputs, then checks the DUT one time unit after the clock edge.
   task automatic applyStimulus(input string tag, input logic rst, input logic sf,
                                input logic sd, input logic fl, input logic src,
                                input logic [31:0] tgt);
      exp_t e;
      logic [31:0] nextPc;
      reset       = rst;
      stall_f     = sf;
      stall_d     = sd;
      flush_d     = fl;
      pc_src_e    = src;
      pc_target_e = tgt;

      if (rst)      nextPc = 32'h0;
      else if (src) nextPc = tgt;
      else if (sf)  nextPc = mPc;
      else          nextPc = mPc + 32'd4;

      if (rst || fl || src) begin
         mInstr = NOP; mPcD = 0; mPc4D = 0; mValid = 0; mMis = 0;
         if (rst) mCount = 0;
      end else if (!sd) begin
         mInstr = memWord(mPc);
         mPcD   = mPc;
         mPc4D  = mPc + 32'd4;
         mValid = 1'b1;
         mMis   = (mPc[1:0] != 2'b00);
         mCount = mCount + 32'd1;
      end
      mPc = nextPc;

      e.addr = mPc; e.instr = mInstr; e.pc = mPcD; e.pc4 = mPc4D;
      e.valid = mValid; e.mis = mMis; e.count = mCount;
      expQ.push_back(e);

      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Directed sequence of steps.
   initial begin
      reset = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
      pc_target_e = 0;
      mPc = 0; mInstr = NOP; mPcD = 0; mPc4D = 0; mValid = 0; mMis = 0; mCount = 0;
      #1;

      $display("[TB] reset and free run");
      applyStimulus("reset", 1, 0, 0, 0, 0, 0);
      checkValue("rst_addr",  instr_addr,  32'h0);
      checkValue("rst_instr", instr_d,     NOP);
      checkValue("rst_count", fetch_count, 32'h0);
      applyStimulus("run0", 0, 0, 0, 0, 0, 0);
      checkValue("run0_instr", instr_d, memWord(32'h0));
      applyStimulus("run1", 0, 0, 0, 0, 0, 0);
      applyStimulus("run2", 0, 0, 0, 0, 0, 0);
      applyStimulus("run3", 0, 0, 0, 0, 0, 0);
      checkValue("run3_instr", instr_d,     memWord(32'hC));
      checkValue("run3_pc",    pc_d,        32'hC);
      checkValue("run3_count", fetch_count, 32'd4);

      $display("[TB] stall at 0x8");
      applyStimulus("reset2", 1, 0, 0, 0, 0, 0);
      applyStimulus("pre0", 0, 0, 0, 0, 0, 0);
      applyStimulus("pre1", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall", 0, 1, 1, 0, 0, 0);
         checkValue("stall_addr",  instr_addr,  32'h8);
         checkValue("stall_count", fetch_count, 32'd2);
      end
      applyStimulus("release", 0, 0, 0, 0, 0, 0);
      checkValue("release_instr", instr_d, memWord(32'h8));
      applyStimulus("runC", 0, 0, 0, 0, 0, 0);

      $display("[TB] redirect to 0x40");
      checkValue("pre_redirect_addr", instr_addr, 32'h10);
      applyStimulus("redir40", 0, 0, 0, 0, 1, 32'h40);
      checkValue("redir40_addr",  instr_addr,             32'h40);
      checkValue("redir40_valid", {31'd0, valid_d},       32'd0);
      applyStimulus("tgt40", 0, 0, 0, 0, 0, 0);
      checkValue("tgt40_instr", instr_d, memWord(32'h40));
      checkValue("tgt40_pc",    pc_d,    32'h40);

      $display("[TB] redirect under stall");
      applyStimulus("redirStall", 0, 1, 1, 0, 1, 32'h80);
      checkValue("redirStall_addr",  instr_addr,  32'h80);
      checkValue("redirStall_count", fetch_count, 32'd5);

      $display("[TB] misaligned redirect and wrap");
      applyStimulus("redir42", 0, 0, 0, 0, 1, 32'h42);
      checkValue("redir42_addr", instr_addr, 32'h42);
      applyStimulus("mis42", 0, 0, 0, 0, 0, 0);
      checkValue("mis42_flag",  {31'd0, misaligned_d}, 32'd1);
      checkValue("mis42_instr", instr_d,               memWord(32'h40));
      applyStimulus("redirTop", 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      applyStimulus("wrap", 0, 0, 0, 0, 0, 0);
      checkValue("wrap_addr", instr_addr, 32'h0);
      checkValue("wrap_pc4",  pc_plus4_d, 32'h0);

      $display("[TB] flush and reset during stall");
      applyStimulus("flush", 0, 0, 0, 1, 0, 0);
      applyStimulus("f4", 0, 0, 0, 0, 0, 0);
      applyStimulus("f8", 0, 0, 0, 0, 0, 0);
      applyStimulus("fC", 0, 0, 0, 0, 0, 0);
      checkValue("ten_count", fetch_count, 32'd10);
      applyStimulus("stallA", 0, 1, 1, 0, 0, 0);
      applyStimulus("stallB", 0, 1, 1, 0, 0, 0);
      applyStimulus("resetStall", 1, 1, 1, 0, 0, 0);
      checkValue("resetStall_addr",  instr_addr,  32'h0);
      checkValue("resetStall_count", fetch_count, 32'd0);
      applyStimulus("postReset", 0, 0, 0, 0, 0, 0);
      checkValue("postReset_pc", pc_d, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
